// File: rtl/bk_alu_result_buffer.sv
// Result FIFO behind the combinational ALU: valid/ready on both sides, plus a
// sticky error flag and a saturating count of accepted errored results.
module bk_alu_result_buffer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2*WIDTH-1:0]       alu_out,
   input  logic                     alu_zero,
   input  logic                     alu_error,
   input  logic                     alu_invalid,
   input  logic [2:0]               alu_opcode,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2*WIDTH-1:0]       out_result,
   output logic                     out_zero,
   output logic                     out_error,
   output logic                     out_invalid,
   output logic [2:0]               out_opcode,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     sticky_error,
   output logic [CNT_W-1:0]         err_count,
   input  logic                     clear_status
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int RW    = 2 * WIDTH;
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] ERR_MAX  = '1;

   typedef struct packed {
      logic [RW-1:0] result;
      logic          zero;
      logic          error;
      logic          invalid;
      logic [2:0]    opcode;
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;

   always_comb begin
      in_ready  = !rst && (count < FULL_CNT);
      out_valid = (count != '0);
      push      = in_valid && in_ready;
      pop       = out_valid && out_ready;
      head      = mem[rd_ptr];
   end

   // Head fields are gated so an empty buffer never exposes stale storage.
   always_comb begin
      out_result  = '0;
      out_zero    = 1'b0;
      out_error   = 1'b0;
      out_invalid = 1'b0;
      out_opcode  = '0;
      if (out_valid) begin
         out_result  = head.result;
         out_zero    = head.zero;
         out_error   = head.error;
         out_invalid = head.invalid;
         out_opcode  = head.opcode;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {alu_out, alu_zero, alu_error, alu_invalid, alu_opcode};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + (PTR_W + 1)'(1);
         else if (pop && !push) count <= count - (PTR_W + 1)'(1);
      end
   end

   // An errored push in the same cycle as clear_status restarts the count at 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_error <= 1'b0;
         err_count    <= '0;
      end else if (push && alu_error) begin
         sticky_error <= 1'b1;
         if (clear_status)             err_count <= CNT_W'(1);
         else if (err_count != ERR_MAX) err_count <= err_count + CNT_W'(1);
      end else if (clear_status) begin
         sticky_error <= 1'b0;
         err_count    <= '0;
      end
   end

endmodule

// File: tb/tb_bk_alu_result_buffer.sv
// Self-checking bench for bk_alu_result_buffer: directed vector table, corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_bk_alu_result_buffer;

   localparam int DEPTH = 4;
   localparam int EMAX  = 255;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] alu_out = '0;
   logic        alu_zero = 1'b0;
   logic        alu_error = 1'b0;
   logic        alu_invalid = 1'b0;
   logic [2:0]  alu_opcode = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_result;
   logic        out_zero;
   logic        out_error;
   logic        out_invalid;
   logic [2:0]  out_opcode;
   logic [2:0]  count;
   logic        sticky_error;
   logic [7:0]  err_count;
   logic        clear_status = 1'b0;

   bk_alu_result_buffer #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_out(alu_out), .alu_zero(alu_zero), .alu_error(alu_error),
      .alu_invalid(alu_invalid), .alu_opcode(alu_opcode),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_zero(out_zero), .out_error(out_error), .out_invalid(out_invalid),
      .out_opcode(out_opcode), .count(count), .sticky_error(sticky_error),
      .err_count(err_count), .clear_status(clear_status)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] r;
      logic        z;
      logic        e;
      logic        i;
      logic [2:0]  op;
   } ent_t;

   typedef struct {
      bit          v;
      bit          rdy;
      logic [15:0] r;
      int          exp_cnt;
      bit          exp_ov;
      logic [15:0] exp_res;
      bit          exp_ir;
   } vec_t;

   int   n_pass = 0;
   int   n_total = 0;
   ent_t q[$];
   int   m_err = 0;
   bit   m_sticky = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic check_model();
      ent_t h;
      h = (q.size() > 0) ? q[0] : '0;
      chk("count", 32'(count), 32'(q.size()));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      chk("out_result", 32'(out_result), 32'(h.r));
      chk("out_zero", 32'(out_zero), 32'(h.z));
      chk("out_error", 32'(out_error), 32'(h.e));
      chk("out_invalid", 32'(out_invalid), 32'(h.i));
      chk("out_opcode", 32'(out_opcode), 32'(h.op));
      chk("sticky_error", 32'(sticky_error), 32'(m_sticky));
      chk("err_count", 32'(err_count), 32'(m_err));
   endtask

   // Called just after a rising edge; drives inputs, advances one cycle, checks.
   task automatic cycle(input bit v, input bit rdy, input ent_t d, input bit clr);
      bit push, pop;
      in_valid = v; out_ready = rdy; clear_status = clr;
      alu_out = d.r; alu_zero = d.z; alu_error = d.e; alu_invalid = d.i; alu_opcode = d.op;
      push = v && (q.size() < DEPTH);
      pop  = rdy && (q.size() > 0);
      @(posedge clk); #1;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
      if (push && d.e) begin
         m_sticky = 1;
         m_err = clr ? 1 : ((m_err < EMAX) ? m_err + 1 : EMAX);
      end else if (clr) begin
         m_sticky = 0;
         m_err = 0;
      end
      check_model();
   endtask

   function automatic ent_t mk(input logic [15:0] r, input bit e, input bit i, input logic [2:0] op);
      ent_t t;
      t.r = r; t.z = (r == 16'h0); t.e = e; t.i = i; t.op = op;
      return t;
   endfunction

   vec_t vt[11];

   initial begin
      vt[0]  = '{1, 0, 16'h0005, 1, 1, 16'h0005, 1};
      vt[1]  = '{0, 1, 16'h0000, 0, 0, 16'h0000, 1};
      vt[2]  = '{1, 0, 16'h0001, 1, 1, 16'h0001, 1};
      vt[3]  = '{1, 0, 16'h0002, 2, 1, 16'h0001, 1};
      vt[4]  = '{1, 0, 16'h0003, 3, 1, 16'h0001, 1};
      vt[5]  = '{1, 0, 16'h0004, 4, 1, 16'h0001, 0};
      vt[6]  = '{1, 0, 16'h0006, 4, 1, 16'h0001, 0};
      vt[7]  = '{1, 1, 16'h0006, 3, 1, 16'h0002, 1};
      vt[8]  = '{0, 1, 16'h0000, 2, 1, 16'h0003, 1};
      vt[9]  = '{0, 1, 16'h0000, 1, 1, 16'h0004, 1};
      vt[10] = '{0, 1, 16'h0000, 0, 0, 16'h0000, 1};

      // Reset state
      #2;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Directed table: single push/pop, fill, full-no-bypass, drain
      foreach (vt[k]) begin
         cycle(vt[k].v, vt[k].rdy, mk(vt[k].r, 0, 0, 3'd0), 0);
         chk($sformatf("vec%0d_count", k), 32'(count), 32'(vt[k].exp_cnt));
         chk($sformatf("vec%0d_out_valid", k), 32'(out_valid), 32'(vt[k].exp_ov));
         chk($sformatf("vec%0d_out_result", k), 32'(out_result), 32'(vt[k].exp_res));
         chk($sformatf("vec%0d_in_ready", k), 32'(in_ready), 32'(vt[k].exp_ir));
      end

      // Continuous push and pop at occupancy 1, pointers wrap
      cycle(1, 0, mk(16'd10, 0, 0, 3'd1), 0);
      for (int k = 1; k < 10; k++) begin
         cycle(1, 1, mk(16'(10 + k), 0, 0, 3'(k)), 0);
         chk("stream_count", 32'(count), 32'd1);
         chk("stream_head", 32'(out_result), 32'(10 + k));
      end
      cycle(0, 1, '0, 0);
      chk("stream_drained", 32'(out_valid), 32'd0);

      // Errored entries keep their flags and opcode
      cycle(1, 0, mk(16'hFFFF, 1, 0, 3'd3), 0);
      cycle(1, 0, mk(16'h0000, 1, 1, 3'd5), 0);
      chk("err_sticky", 32'(sticky_error), 32'd1);
      chk("err_count2", 32'(err_count), 32'd2);
      chk("err_head_op", 32'(out_opcode), 32'd3);
      chk("err_head_inv", 32'(out_invalid), 32'd0);
      cycle(0, 1, '0, 0);
      chk("err_head2_op", 32'(out_opcode), 32'd5);
      chk("err_head2_inv", 32'(out_invalid), 32'd1);
      chk("err_head2_err", 32'(out_error), 32'd1);
      cycle(0, 1, '0, 0);

      // Saturation, then clear colliding with an errored push
      for (int k = 0; k < 260; k++) cycle(1, 1, mk(16'(k), 1, 0, 3'd2), 0);
      chk("err_saturated", 32'(err_count), 32'd255);
      cycle(1, 1, mk(16'h1234, 1, 0, 3'd2), 1);
      chk("clear_vs_push_cnt", 32'(err_count), 32'd1);
      chk("clear_vs_push_sticky", 32'(sticky_error), 32'd1);
      cycle(0, 1, '0, 1);
      chk("clear_cnt", 32'(err_count), 32'd0);
      chk("clear_sticky", 32'(sticky_error), 32'd0);

      // Randomized traffic against the model
      for (int k = 0; k < 600; k++) begin
         ent_t d;
         bit e;
         e = ($urandom_range(0, 3) == 0);
         d = mk(($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom), e, e && $urandom_range(0, 1) == 1,
                3'($urandom));
         cycle($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, d, $urandom_range(0, 30) == 0);
      end

      // Reset mid-stream with 3 entries buffered
      while (q.size() > 0) cycle(0, 1, '0, 0);
      for (int k = 0; k < 3; k++) cycle(1, 0, mk(16'(16'h0100 + k), 0, 0, 3'd4), 0);
      chk("pre_rst_count", 32'(count), 32'd3);
      rst = 1'b1;
      #1;
      q.delete(); m_err = 0; m_sticky = 0;
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_result", 32'(out_result), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("after_rst_in_ready", 32'(in_ready), 32'd1);
      cycle(1, 0, mk(16'h0042, 0, 0, 3'd6), 0);
      chk("after_rst_head", 32'(out_result), 32'h0042);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/bk_alu_result_buffer.md
Name: bk_alu_result_buffer

Overview:
Downstream stage of the combinational 8-bit ALU. Captures each ALU result (16-bit value, zero/error/invalid flags, opcode tag) on a valid/ready handshake into a small FIFO, then presents results to the writeback/output logic through a second valid/ready handshake. Also keeps a sticky error flag and a saturating error counter for status readout. This decouples ALU issue from a stalling consumer.

Parameters:
WIDTH, 8, ALU operand width; stored result is 2*WIDTH bits.
DEPTH, 4, FIFO entries; power of two, >= 2.
CNT_W, 8, error counter width.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  ALU result valid this cycle
in_ready  out  1  buffer can accept an entry
alu_out  in  2*WIDTH  ALU result
alu_zero  in  1  ALU zero flag
alu_error  in  1  ALU error flag (div-by-0 or bad opcode)
alu_invalid  in  1  ALU invalid-opcode flag
alu_opcode  in  3  opcode tag travelling with the result
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head entry
out_result  out  2*WIDTH  head result
out_zero  out  1  head zero flag
out_error  out  1  head error flag
out_invalid  out  1  head invalid flag
out_opcode  out  3  head opcode tag
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
sticky_error  out  1  set when any errored entry is accepted
err_count  out  CNT_W  number of accepted errored entries, saturating
clear_status  in  1  synchronous clear of sticky_error and err_count

Behaviour:
- Reset (rst=1, async): count=0, rd/wr pointers=0, out_valid=0, all out_* fields=0, sticky_error=0, err_count=0, in_ready=0 while rst is high; storage contents need no reset.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = !rst & (count < DEPTH). No bypass: a full buffer does not accept a push in the same cycle as a pop; in_ready rises the cycle after the pop.
- out_valid = (count != 0). out_* fields show the head entry combinationally from storage when out_valid=1; they are forced to 0 when empty.
- Latency: an entry pushed into an empty buffer at edge N is visible (out_valid=1) after edge N; minimum 1 cycle, no same-cycle pass-through.
- Ordering: strict FIFO; all five fields of an entry stay together.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count: +1 on push only, -1 on pop only, unchanged on push&pop.
- Inputs not pushed (in_valid=0 or in_ready=0) are ignored; upstream holds alu_* stable while in_valid & !in_ready.
- Pop with out_ready=1 when empty: no effect.
- Status: on a push with alu_error=1, sticky_error<=1 and err_count<=err_count+1, saturating at 2^CNT_W-1. The count is driven by alu_error only; alu_invalid implies alu_error from the ALU and is not counted separately.
- clear_status=1: sticky_error<=0, err_count<=0, unless an errored push occurs in the same cycle; then sticky_error<=1 and err_count<=1 (new event wins over clear).
- clear_status does not affect FIFO contents or pointers.
- Reset mid-operation: all buffered entries are discarded immediately; out_valid drops asynchronously.

Test Plan:
- Reset then single push alu_out=16'h0005, opcode=0, out_ready=0 -> next cycle out_valid=1, out_result=0005, count=1, in_ready=1; assert out_ready -> out_valid=0, count=0 next cycle.
- Push 4 entries (results 1,2,3,4) with out_ready=0 -> count=4, in_ready=0; a 5th in_valid is not accepted. Drain with out_ready=1 -> outputs 1,2,3,4 in order, then out_valid=0.
- Continuous push and pop every cycle for 10 entries (values 10..19), starting from count=1 -> count stays 1, pointers wrap past DEPTH, outputs in order with no loss or duplication.
- Push opcode=3 with alu_error=1, alu_out=16'hFFFF, then opcode=5 with alu_error=1, alu_invalid=1 -> sticky_error=1, err_count=2; head flags match per entry.
- Set err_count to 255 by repeated errored pushes, push one more -> err_count stays 255. Assert clear_status with an errored push in the same cycle -> err_count=1, sticky_error=1.
- With 3 entries buffered, assert rst for one cycle mid-stream -> count=0, out_valid=0, out_result=0, in_ready=0 during reset and 1 after reset.
